histogram_readout: RTL and testbench

Readout sequencer that sits directly downstream of the four histogram lanes. On a start pulse it walks bin addresses 0..BINS-1 and drives them onto the lanes' shared address bus. For each bin it sums the lane counts into a merged total and streams one result per bin over a valid/ready interface. While busy it asserts a freeze signal so the upstream enable logic stops counting, and it can optionally pulse a clear to the lanes when the sweep finishes.

---
 rtl/histogram_readout.sv | 145 ++++++++++++++
 tb/tb_histogram_readout.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_readout.sv
// histogram_readout
//
// Readout sequencer for the histogram lanes. A start pulse launches a sweep
// over bin addresses 0..BINS-1. For each bin the address goes out on the
// shared lane address bus, the registered lane counts come back one cycle
// later, and their unsigned sum is offered on a valid/ready stream. The
// block reports itself busy (and freezes the upstream counters) for the
// whole sweep. It can optionally pulse a clear to the lanes when the sweep
// completes.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   start          one-cycle sweep request, honoured only when idle
//   clear_on_done  sampled with start; requests a lane_clear at sweep end
//   hist_addr      bin address driven to all lanes
//   lane_hist      lane counts for hist_addr, lane 0 in the low BIN_W bits
//   freeze         high while busy; upstream gates lane enables with it
//   lane_clear     one-cycle clear pulse to the lanes, coincident with done
//   out_valid      merged result available
//   out_ready      consumer accepts the merged result
//   out_bin        bin index of out_sum
//   out_sum        sum of all lane counts for out_bin
//   out_last       marks the final bin of the sweep
//   busy           sequencer not idle
//   done           one-cycle pulse when a sweep completes

module histogram_readout #(
  parameter int LANES  = 4,
  parameter int BINS   = 8,
  parameter int BIN_W  = 14,
  parameter int ADDR_W = 3,
  parameter int SUM_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear_on_done,
  output logic [ADDR_W-1:0]        hist_addr,
  input  logic [LANES*BIN_W-1:0]   lane_hist,
  output logic                     freeze,
  output logic                     lane_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_bin,
  output logic [SUM_W-1:0]         out_sum,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   bin;
  logic                clr_req;
  logic [SUM_W-1:0]    lane_sum;

  // The bin register is the lane address bus; it only moves between bins,
  // so it stays put while a result is stalled in PRESENT.
  assign hist_addr = bin;
  assign freeze    = busy;

  // Zero-extended sum of all lane fields; SUM_W is wide enough that the
  // largest possible total cannot wrap.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + SUM_W'(lane_hist[l*BIN_W +: BIN_W]);
    end
  end

  // Sweep sequencer with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bin        <= '0;
      clr_req    <= 1'b0;
      out_sum    <= '0;
      out_bin    <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lane_clear <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            bin     <= '0;
            clr_req <= clear_on_done;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          // Lanes register hist_addr at this edge; data is valid next cycle.
          state <= CAPTURE;
        end
        CAPTURE: begin
          out_sum   <= lane_sum;
          out_bin   <= bin;
          out_last  <= (bin == LAST_BIN);
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state      <= DONE;
              done       <= 1'b1;
              lane_clear <= clr_req;
            end else begin
              bin   <= bin + ADDR_W'(1);
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done       <= 1'b0;
          lane_clear <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          lane_clear <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_readout.sv
// Testbench for histogram_readout: lane memory model, scoreboard monitor and
// a directed/randomised stimulus sequence.
module tb_histogram_readout;

  localparam int LANES  = 4;
  localparam int BINS   = 8;
  localparam int BIN_W  = 14;
  localparam int ADDR_W = 3;
  localparam int SUM_W  = 16;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic                    clear_on_done = 1'b0;
  logic [ADDR_W-1:0]       hist_addr;
  logic [LANES*BIN_W-1:0]  lane_hist;
  logic                    freeze;
  logic                    lane_clear;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [ADDR_W-1:0]       out_bin;
  logic [SUM_W-1:0]        out_sum;
  logic                    out_last;
  logic                    busy;
  logic                    done;

  histogram_readout #(
    .LANES(LANES), .BINS(BINS), .BIN_W(BIN_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .clear_on_done(clear_on_done),
    .hist_addr(hist_addr), .lane_hist(lane_hist), .freeze(freeze),
    .lane_clear(lane_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_sum(out_sum), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Lane model: registered read of the addressed bin, bulk load and clear.
  logic [BIN_W-1:0] load_val [LANES][BINS];
  logic [BIN_W-1:0] mem      [LANES][BINS];
  logic             load = 1'b0;

  always @(posedge clock) begin
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < BINS; b++) begin
        if (lane_clear) mem[l][b] <= '0;
        else if (load)  mem[l][b] <= load_val[l][b];
      end
      lane_hist[l*BIN_W +: BIN_W] <= mem[l][hist_addr];
    end
  end

  typedef struct {
    int bin;
    int sum;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   exp_active = 1'b0;
  bit   exp_done = 1'b0;
  bit   exp_clr = 1'b0;
  bit   ref_cleared = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: a sweep accepted from idle yields one result per bin,
  // each the plain sum of the lane contents; done follows the last transfer.
  task automatic monitor();
    exp_t it;
    bit   nxt_active;
    bit   nxt_done;
    int   s;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("busy", busy, exp_active);
        chk("freeze", freeze, exp_active);
        chk("done", done, exp_done);
        chk("lane_clear", lane_clear, exp_done && exp_clr);
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_valid actual=out_valid=1 expected=no pending result at %0t", $time);
          end else begin
            chk("out_bin", out_bin, sb[0].bin);
            chk("out_sum", out_sum, sb[0].sum);
            chk("out_last", out_last, sb[0].last);
            chk("hist_addr_hold", hist_addr, sb[0].bin);
          end
        end
      end
      nxt_active = exp_active;
      nxt_done   = 1'b0;
      if (exp_done) begin
        nxt_active = 1'b0;
        if (exp_clr) ref_cleared = 1'b1;
        chk("results_left_at_done", sb.size(), 0);
      end
      if (!reset && out_valid === 1'b1 && out_ready && sb.size() > 0) begin
        it = sb.pop_front();
        if (it.last) nxt_done = 1'b1;
      end
      if (!reset && start && !exp_active) begin
        for (int b = 0; b < BINS; b++) begin
          s = 0;
          if (!ref_cleared)
            for (int l = 0; l < LANES; l++) s += int'(load_val[l][b]);
          it.bin  = b;
          it.sum  = s;
          it.last = (b == BINS - 1);
          sb.push_back(it);
        end
        nxt_active = 1'b1;
        exp_clr    = clear_on_done;
      end
      if (load) ref_cleared = 1'b0;
      if (reset) begin
        sb.delete();
        nxt_active = 1'b0;
        nxt_done   = 1'b0;
        exp_clr    = 1'b0;
      end
      exp_active = nxt_active;
      exp_done   = nxt_done;
    end
  endtask

  task automatic fill(input int pat);
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < BINS; b++) begin
        case (pat)
          0:       load_val[l][b] = BIN_W'((l + 1) * b);
          1:       load_val[l][b] = BIN_W'(16383);
          2:       load_val[l][b] = BIN_W'($urandom_range(0, 16383));
          default: load_val[l][b] = '0;
        endcase
      end
    end
    tick();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input bit clr);
    tick();
    start = 1'b1;
    clear_on_done = clr;
    tick();
    start = 1'b0;
  endtask

  // Runs from cycle 0 of a sweep until done; mode 0 ready high,
  // 1 stall at bin 3 then toggle, 2 random ready.
  task automatic sweep(input int mode, output int done_at, output int first_valid);
    int bp;
    bp = 0;
    done_at = -1;
    first_valid = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (out_valid && first_valid < 0) first_valid = n;
      if (done) begin
        done_at = n;
        break;
      end
      if (mode == 1 && bp == 0 && hist_addr == ADDR_W'(3) && !out_valid) bp = 1;
      tick();
      case (mode)
        1: begin
          if (bp >= 1 && bp <= 6) begin
            out_ready = 1'b0;
            bp++;
          end else if (bp > 6) begin
            out_ready = !out_ready;
          end else begin
            out_ready = 1'b1;
          end
        end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
    if (done_at < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done expected=done within 400 cycles");
    end
    tick();
    out_ready = 1'b1;
  endtask

  initial begin
    int  done_at;
    int  fv;
    bit  extra;
    bit  obs_extra;
    bit  obs_last;
    bit  seen;
    bit  stop4;

    fork
      monitor();
    join_none

    // Reset state.
    tick();
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_hist_addr", hist_addr, 0);
    chk("rst_done", done, 0);

    // Basic sweep: lane l bin b holds (l+1)*b, totals 10*b.
    fill(0);
    do_start(1'b0);
    sweep(0, done_at, fv);
    chk("basic_done_cycle", done_at, 3 * BINS);
    chk("basic_first_valid_cycle", fv, 2);

    // Maximum lane values: 4*16383 = 65532 must not wrap.
    fill(1);
    do_start(1'b0);
    sweep(0, done_at, fv);
    chk("max_done_cycle", done_at, 3 * BINS);

    // Backpressure at bin 3, then toggling ready.
    fill(2);
    do_start(1'b0);
    sweep(1, done_at, fv);
    chk("bp_done_late", done_at > 3 * BINS, 1);

    // Clear on done, extra start mid-sweep, start in DONE cycle ignored,
    // start in first idle cycle accepted.
    fill(2);
    do_start(1'b1);
    extra = 1'b0;
    seen  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
      obs_extra = (hist_addr == ADDR_W'(2)) && !extra;
      obs_last  = out_valid && out_last && out_ready;
      tick();
      start = 1'b0;
      if (obs_extra) begin
        start = 1'b1;
        extra = 1'b1;
      end
      if (obs_last) begin
        start = 1'b1;
        clear_on_done = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL clear_done_timeout actual=no done expected=done within 400 cycles");
    end
    tick();
    tick();
    start = 1'b0;
    sweep(0, done_at, fv);
    chk("zero_sweep_done_cycle", done_at, 3 * BINS);

    // Reset during PRESENT of bin 4, then a fresh sweep with random ready.
    fill(2);
    do_start(1'b0);
    seen  = 1'b0;
    stop4 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (out_valid && out_bin == ADDR_W'(4)) begin
        seen = 1'b1;
        break;
      end
      if (hist_addr == ADDR_W'(4)) stop4 = 1'b1;
      tick();
      out_ready = !stop4;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL bin4_timeout actual=bin 4 never presented expected=bin 4 presented");
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_out_bin", out_bin, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_hist_addr", hist_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lane_clear", lane_clear, 0);
    repeat (4) tick();
    do_start(1'b0);
    sweep(2, done_at, fv);
    chk("restart_first_valid_cycle", fv, 2);

    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
